// File: rtl/pipe_stage_buf_pkg.sv
// Shared control definitions for the two-entry pipeline stage buffer:
// state encoding and statistics-counter enable constants.
package pipe_stage_buf_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic CNT_INC  = 1'b1;
  localparam logic CNT_HOLD = 1'b0;

  // A stall is an upstream offer that is refused, outside a flush.
  function automatic logic stall_en(
    input logic valid,
    input logic ready,
    input logic flush
  );
    return (valid && !ready && !flush) ? CNT_INC : CNT_HOLD;
  endfunction

  function automatic logic flush_en(input logic flush);
    return flush ? CNT_INC : CNT_HOLD;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter used for the buffer statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count enabled cycles, holding once the top value is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between pipeline stages (head + skid).
// All outputs come straight from registers.
module pipe_stage_buf #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import pipe_stage_buf_pkg::*;

  logic [1:0]       state;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] skid;
  logic             push;
  logic             pop;
  logic             stall_inc;
  logic             flush_inc;

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = head;
  assign occupancy = state;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign stall_inc = stall_en(in_valid, in_ready, flush);
  assign flush_inc = flush_en(flush);

  // Entry state machine; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state <= ST_EMPTY;
      head  <= FLUSH_VAL;
      skid  <= FLUSH_VAL;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            head  <= in_data;
            state <= ST_HALF;
          end
        end
        ST_HALF: begin
          if (push && pop) begin
            head <= in_data;
          end else if (push) begin
            skid  <= in_data;
            state <= ST_FULL;
          end else if (pop) begin
            head  <= FLUSH_VAL;
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            head  <= skid;
            skid  <= FLUSH_VAL;
            state <= ST_HALF;
          end
        end
        default: begin
          state <= ST_EMPTY;
          head  <= FLUSH_VAL;
          skid  <= FLUSH_VAL;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: driver keeps a queue model,
// monitor checks outputs mid-cycle against it.
module tb_pipe_stage_buf;

  localparam int          W    = 64;
  localparam int          CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;
  localparam logic [W-1:0] FV  = 64'hDEAD_BEEF_0BAD_F00D;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          flush;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  pipe_stage_buf #(.WIDTH(W), .FLUSH_VAL(FV), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: contents in FIFO order, counters as plain ints
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_q[$];
  int m_stall = 0;
  int m_flush = 0;

  // model view valid during the current cycle
  bit chk_en = 0;
  int snap_occ;
  int snap_stall;
  int snap_flush;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of inputs and advance the model across the next edge.
  task automatic drive(input logic r, input logic iv, input logic [W-1:0] d,
                       input logic ordy, input logic fl, output logic acc);
    @(posedge clk);
    #1;
    reset     = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    snap_occ   = mq.size();
    snap_stall = m_stall;
    snap_flush = m_flush;
    chk_en     = 1;
    acc        = 1'b0;
    if (r) begin
      mq.delete();
      m_stall = 0;
      m_flush = 0;
    end else if (fl) begin
      mq.delete();
      if (m_flush < CMAX) m_flush++;
    end else begin
      if (iv && mq.size() == 2 && m_stall < CMAX) m_stall++;
      acc = iv && (mq.size() < 2);
      if (ordy && mq.size() > 0) exp_q.push_back(mq.pop_front());
      if (acc) mq.push_back(d);
    end
  endtask

  // Monitor: level checks plus scoreboard pop on each real transfer.
  always @(negedge clk) begin
    if (chk_en) begin
      check("occupancy", W'(occupancy), W'(snap_occ));
      check("in_ready", W'(in_ready), W'(snap_occ < 2));
      check("out_valid", W'(out_valid), W'(snap_occ > 0));
      check("stall_cnt", W'(stall_cnt), W'(snap_stall));
      check("flush_cnt", W'(flush_cnt), W'(snap_flush));
      if (snap_occ == 0) check("bubble_data", out_data, FV);
      if (out_valid && out_ready && !flush && !reset) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got %h, expected none", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  logic acc;

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) drive(0, 0, W'($urandom), ordy, 0, acc);
  endtask

  // Offer one payload until taken; a refusal past the bound is an error.
  task automatic send(input logic [W-1:0] d, input logic ordy);
    int k = 0;
    do begin
      drive(0, 1, d, ordy, 0, acc);
      k++;
    end while (!acc && k < 50);
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got refused, expected accept of %h", d);
    end
  endtask

  task automatic do_reset();
    drive(1, 0, '0, 0, 0, acc);
  endtask

  initial begin
    logic [W-1:0] pa;
    logic [W-1:0] pb;
    logic [W-1:0] pc;
    reset     = 1;
    in_valid  = 0;
    in_data   = '0;
    out_ready = 0;
    flush     = 0;
    repeat (2) @(posedge clk);

    // reset state, then single transfer
    do_reset();
    drive(0, 1, 64'h00400000_24080005, 1, 0, acc);
    idle(1, 3);

    // backpressure: A, B held, C blocked for a few cycles
    pa = 64'hA000_0000_0000_000A;
    pb = 64'hB000_0000_0000_000B;
    pc = 64'hC000_0000_0000_000C;
    send(pa, 0);
    send(pb, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, pc, 0, 0, acc);
    send(pc, 1);
    idle(1, 3);

    // streaming ten payloads from a clean reset
    do_reset();
    for (int i = 0; i < 10; i++) drive(0, 1, W'(64'h1000 + i), 1, 0, acc);
    idle(1, 3);

    // flush while full with a push offered
    do_reset();
    send(64'h1111, 0);
    send(64'h2222, 0);
    drive(0, 1, 64'h3333_DEAD, 1, 1, acc);
    idle(1, 3);

    // flush counter saturation
    for (int i = 0; i < 20; i++) drive(0, 0, '0, 0, 1, acc);
    idle(0, 2);

    // reset while full and downstream ready
    send(64'h4444, 0);
    send(64'h5555, 0);
    drive(1, 1, 64'h6666, 1, 0, acc);
    idle(1, 3);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) != 0),
            {$urandom, $urandom},
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 24) == 0),
            acc);
    end
    idle(1, 4);

    @(negedge clk);
    #1;
    check("drained", W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
